fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter: DEPTH, 16, program buffer entries (power of two, >=2).
REQ-002 Parameter: AW, 4, PC width, log2(DEPTH).
REQ-003 Parameter: WDOG_LIM, 15, watchdog limit in EXEC cycles (used only under FETCH_WDOG_EN).
REQ-004 i_clk  in  1  sole clock, all state on rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_prog_we  in  1  program buffer write strobe.
REQ-007 i_prog_addr  in  AW  program buffer write address.
REQ-008 i_prog_data  in  2  instruction to write (00 NOP, 11 Load, 10 Add, 01 reserved).
REQ-009 i_prog_len  in  AW+1  instructions in program, 0..DEPTH.
REQ-010 i_run  in  1  level; start execution from PC 0.
REQ-011 i_halt  in  1  level; stop at next instruction boundary.
REQ-012 i_pcincr  in  1  decode completion pulse; current instruction retired.
REQ-013 o_instr  out  2  registered instruction presented to decode.
REQ-014 o_start  out  1  one-cycle pulse marking a new instruction on o_instr.
REQ-015 o_pc  out  AW  address of instruction on o_instr.
REQ-016 o_busy  out  1  high in ISSUE or EXEC.
REQ-017 o_done  out  1  high in DONE.
REQ-018 o_err  out  1  sticky watchdog error.

Function
REQ-019 States IDLE, ISSUE, EXEC, DONE; o_start=1 only in ISSUE, o_busy=1 in ISSUE/EXEC, o_done=1 only in DONE.
REQ-020 Program writes take effect only in IDLE or DONE; writes in ISSUE/EXEC are dropped.
REQ-021 IDLE: i_run=1 and i_prog_len!=0 -> ISSUE, pc=0, o_instr=buf[0] next edge; i_run=1 and i_prog_len=0 -> DONE.
REQ-022 o_instr and o_pc register on every entry into ISSUE and hold stable through ISSUE and EXEC (decode samples up to 8 cycles).
REQ-023 ISSUE lasts exactly one cycle; i_pcincr=0 there -> EXEC; i_pcincr=1 there (same-cycle NOP retire) -> advance.
REQ-024 EXEC: waits indefinitely for i_pcincr=1, then advances.
REQ-025 Advance: if pc+1==i_prog_len -> DONE; else if i_halt=1 -> IDLE; else -> ISSUE with pc+1; 1-cycle gap-free re-issue (ISSUE follows retire edge directly).
REQ-026 Completion takes priority over i_halt when both apply at the last instruction.
REQ-027 i_halt outside an advance cycle has no effect; i_pcincr in IDLE/DONE ignored.
REQ-028 IDLE and DONE drive o_instr=00 (NOP); o_pc holds last value.
REQ-029 DONE -> IDLE when i_run=0; i_run held high keeps DONE (no auto-restart).
REQ-030 i_prog_len sampled continuously; changing it mid-run is not supported (undefined end point, no hang beyond pc wrap at DEPTH).
REQ-031 pc wraps modulo DEPTH; i_prog_len=DEPTH ends after address DEPTH-1.

Reset
REQ-032 i_rst_n=0 asynchronously forces IDLE, pc=0, o_instr=00, o_start=0, o_busy=0, o_done=0, o_err=0, watchdog count=0.
REQ-033 Program buffer contents are not reset.
REQ-034 Reset mid-EXEC aborts the instruction; no o_start until a new i_run after release.

Configuration
REQ-035 FETCH_WDOG_EN defined: counter clears on ISSUE, increments each EXEC cycle without i_pcincr; on reaching WDOG_LIM -> o_err=1 (sticky until reset), state IDLE.
REQ-036 FETCH_WDOG_EN undefined: no counter, o_err tied 0, EXEC waits forever.

Verification
REQ-037 Write buf={11,00,11}, len=3, i_run=1, decode retires Load at 8th cycle, NOP same-cycle -> o_start pulses at pc 0,1,2; o_instr 11,00,11 stable; o_done after third retire.
REQ-038 len=0, i_run=1 -> DONE next edge, no o_start pulse.
REQ-039 i_halt=1 during retire of pc 1 of len 4 -> IDLE, o_pc=1, no further o_start; i_halt at last retire -> DONE.
REQ-040 Write to addr 2 during EXEC -> buffer unchanged on readback run.
REQ-041 FETCH_WDOG_EN, i_pcincr never asserted -> o_err=1 after 15 EXEC cycles, state IDLE; without macro o_busy stays 1 for 100 cycles.
REQ-042 i_rst_n=0 mid-EXEC at pc 2 -> all outputs reset asynchronously; after release, i_run restarts at pc 0.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch bus: program load, run control and decode handshake between the fetch unit and its neighbours.
interface fetch_if #(parameter int AW = 4);
  logic          i_prog_we;
  logic [AW-1:0] i_prog_addr;
  logic [1:0]    i_prog_data;
  logic [AW:0]   i_prog_len;
  logic          i_run;
  logic          i_halt;
  logic          i_pcincr;
  logic [1:0]    o_instr;
  logic          o_start;
  logic [AW-1:0] o_pc;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  modport slave (
    input  i_prog_we, i_prog_addr, i_prog_data, i_prog_len, i_run, i_halt, i_pcincr,
    output o_instr, o_start, o_pc, o_busy, o_done, o_err
  );

  modport master (
    output i_prog_we, i_prog_addr, i_prog_data, i_prog_len, i_run, i_halt, i_pcincr,
    input  o_instr, o_start, o_pc, o_busy, o_done, o_err
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch sequencer: presents program-buffer entries to decode one at a time.
// Optional execution watchdog enabled by defining FETCH_WDOG_EN.
module fetch #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int WDOG_LIM = 15
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  fetch_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_DONE} state_t;

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [1:0]    r_instr;
  logic          r_start;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_mem [DEPTH];

  logic [AW-1:0] w_pc_nxt;
  logic          w_last;
  logic          w_prog_ok;

  if (DEPTH != (1 << AW) || DEPTH < 2 || WDOG_LIM < 1) begin : g_param_check
    $error("fetch: inconsistent DEPTH/AW/WDOG_LIM");
  end

`ifdef FETCH_WDOG_EN
  localparam int WW = $clog2(WDOG_LIM + 1);
  localparam logic [WW-1:0] WDOG_TRIP = WW'(WDOG_LIM - 1);
  logic [WW-1:0] r_wdog;
`endif

  // Compare in AW+1 bits so a full-depth program terminates after address DEPTH-1.
  assign w_pc_nxt  = r_pc + PC_ONE;
  assign w_last    = ({1'b0, r_pc} + {{AW{1'b0}}, 1'b1}) == bus.i_prog_len;
  assign w_prog_ok = (r_state == S_IDLE) || (r_state == S_DONE);

  // Buffer is deliberately outside the reset domain so a program survives reset.
  always_ff @(posedge i_clk) begin
    if (w_prog_ok && bus.i_prog_we)
      r_mem[bus.i_prog_addr] <= bus.i_prog_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= 2'b00;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef FETCH_WDOG_EN
      r_wdog  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_run) begin
            if (bus.i_prog_len != '0) begin
              r_state <= S_ISSUE;
              r_pc    <= '0;
              r_instr <= r_mem[0];
              r_start <= 1'b1;
              r_busy  <= 1'b1;
`ifdef FETCH_WDOG_EN
              r_wdog  <= '0;
`endif
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_ISSUE, S_EXEC: begin
          r_start <= 1'b0;
          if (bus.i_pcincr) begin
            // Completion wins over halt on the last instruction.
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_instr <= 2'b00;
            end else if (bus.i_halt) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_instr <= 2'b00;
            end else begin
              r_state <= S_ISSUE;
              r_pc    <= w_pc_nxt;
              r_instr <= r_mem[w_pc_nxt];
              r_start <= 1'b1;
`ifdef FETCH_WDOG_EN
              r_wdog  <= '0;
`endif
            end
          end else if (r_state == S_ISSUE) begin
            r_state <= S_EXEC;
`ifdef FETCH_WDOG_EN
          end else if (r_wdog == WDOG_TRIP) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_instr <= 2'b00;
          end else begin
            r_wdog  <= r_wdog + 1'b1;
`endif
          end
        end

        S_DONE: begin
          if (!bus.i_run) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_instr = r_instr;
  assign bus.o_start = r_start;
  assign bus.o_pc    = r_pc;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
`ifdef FETCH_WDOG_EN
  assign bus.o_err   = r_err;
`else
  assign bus.o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed plus randomized bench for the fetch sequencer against a transaction-level program model.
module tb_fetch;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [1:0] mem_m [DEPTH];

  fetch_if #(.AW(AW)) bus ();

  fetch #(.DEPTH(DEPTH), .AW(AW), .WDOG_LIM(15)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_prog(input int addr, input logic [1:0] d);
    bus.i_prog_we   = 1'b1;
    bus.i_prog_addr = AW'(addr);
    bus.i_prog_data = d;
    @(negedge clk);
    bus.i_prog_we   = 1'b0;
    mem_m[addr]     = d;
  endtask

  task automatic load_random(input int len);
    for (int i = 0; i < len; i++) write_prog(i, 2'($urandom));
  endtask

  // Runs one program: fixed<0 means random decode latency, else Loads take fixed extra cycles, NOPs retire at once.
  task automatic run_prog(input int len, input int halt_at, input int fixed);
    int n;
    int w;
    logic [1:0] ei;
    bus.i_prog_len = (AW+1)'(len);
    bus.i_run = 1'b1;
    @(negedge clk);
    bus.i_run = 1'b0;
    if (len == 0) begin
      chk("len0_done", bus.o_done, 1);
      chk("len0_start", bus.o_start, 0);
      @(negedge clk);
      chk("len0_back_idle", bus.o_done, 0);
      return;
    end
    n = (halt_at >= 0 && halt_at < len - 1) ? halt_at + 1 : len;
    for (int k = 0; k < n; k++) begin
      ei = mem_m[k];
      chk("issue_start", bus.o_start, 1);
      chk("issue_pc", bus.o_pc, k);
      chk("issue_instr", bus.o_instr, ei);
      chk("issue_busy", bus.o_busy, 1);
      chk("issue_done", bus.o_done, 0);
      if (fixed >= 0) w = (ei == 2'b00) ? 0 : fixed;
      else            w = $urandom_range(0, 7);
      for (int j = 0; j < w; j++) begin
        bus.i_pcincr    = 1'b0;
        bus.i_prog_we   = 1'($urandom);
        bus.i_prog_addr = AW'($urandom);
        bus.i_prog_data = 2'($urandom);
        bus.i_halt      = 1'($urandom);
        @(negedge clk);
        chk("exec_start", bus.o_start, 0);
        chk("exec_instr", bus.o_instr, ei);
        chk("exec_pc", bus.o_pc, k);
      end
      bus.i_prog_we = 1'b0;
      bus.i_pcincr  = 1'b1;
      bus.i_halt    = (k == halt_at);
      @(negedge clk);
      bus.i_pcincr  = 1'b0;
      bus.i_halt    = 1'b0;
    end
    if (n == len) begin
      chk("end_done", bus.o_done, 1);
      chk("end_busy", bus.o_busy, 0);
      chk("end_instr", bus.o_instr, 0);
      chk("end_pc", bus.o_pc, len - 1);
      @(negedge clk);
      chk("end_back_idle", bus.o_done, 0);
    end else begin
      chk("halt_busy", bus.o_busy, 0);
      chk("halt_done", bus.o_done, 0);
      chk("halt_instr", bus.o_instr, 0);
      chk("halt_pc", bus.o_pc, halt_at);
      for (int j = 0; j < 3; j++) begin
        bus.i_pcincr = 1'($urandom);
        @(negedge clk);
        chk("halt_no_start", bus.o_start, 0);
      end
      bus.i_pcincr = 1'b0;
    end
  endtask

  initial begin
    bus.i_prog_we   = 1'b0;
    bus.i_prog_addr = '0;
    bus.i_prog_data = 2'b00;
    bus.i_prog_len  = '0;
    bus.i_run       = 1'b0;
    bus.i_halt      = 1'b0;
    bus.i_pcincr    = 1'b0;
    #1;
    chk("rst_start", bus.o_start, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_instr", bus.o_instr, 0);
    chk("rst_pc", bus.o_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load, NOP, Load with decode latency of 8 cycles for Loads.
    write_prog(0, 2'b11);
    write_prog(1, 2'b00);
    write_prog(2, 2'b11);
    run_prog(3, -1, 7);

    // Empty program: DONE held while run stays high.
    bus.i_prog_len = '0;
    bus.i_run = 1'b1;
    @(negedge clk);
    chk("len0_hold_done", bus.o_done, 1);
    chk("len0_hold_start", bus.o_start, 0);
    chk("len0_hold_busy", bus.o_busy, 0);
    @(negedge clk);
    chk("len0_still_done", bus.o_done, 1);
    bus.i_run = 1'b0;
    @(negedge clk);
    chk("len0_release", bus.o_done, 0);

    load_random(4);
    run_prog(4, 1, -1);
    run_prog(4, 3, -1);

    // Stall at pc 2, attempt a write during EXEC, then reset asynchronously.
    bus.i_prog_len = 5'd4;
    bus.i_run = 1'b1;
    @(negedge clk);
    bus.i_run = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rs_issue_pc", bus.o_pc, k);
      bus.i_pcincr = 1'b1;
      @(negedge clk);
      bus.i_pcincr = 1'b0;
    end
    chk("rs_pc2", bus.o_pc, 2);
    chk("rs_pc2_start", bus.o_start, 1);
    chk("rs_pc2_instr", bus.o_instr, mem_m[2]);
`ifdef FETCH_WDOG_EN
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      chk("wdog_busy", bus.o_busy, 1);
    end
    @(negedge clk);
    chk("wdog_err", bus.o_err, 1);
    chk("wdog_idle_busy", bus.o_busy, 0);
    chk("wdog_idle_instr", bus.o_instr, 0);
`else
    bus.i_prog_we   = 1'b1;
    bus.i_prog_addr = AW'(2);
    bus.i_prog_data = ~mem_m[2];
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      bus.i_prog_we = 1'b0;
      chk("stall_busy", bus.o_busy, 1);
    end
    chk("stall_instr", bus.o_instr, mem_m[2]);
    chk("stall_err", bus.o_err, 0);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", bus.o_start, 0);
    chk("arst_busy", bus.o_busy, 0);
    chk("arst_done", bus.o_done, 0);
    chk("arst_err", bus.o_err, 0);
    chk("arst_instr", bus.o_instr, 0);
    chk("arst_pc", bus.o_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_start", bus.o_start, 0);
    run_prog(4, -1, -1);

    // Random programs, latencies, halts and background noise.
    for (int t = 0; t < 25; t++) begin
      int len;
      int h;
      len = $urandom_range(0, DEPTH);
      load_random(len);
      h = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, DEPTH);
      run_prog(len, h, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
